// File: rtl/output_arbiter_5.sv
// Round-robin output-port arbiter for the 5-port router crossbar, one instance per output.
// Define OUTPUT_ARB_LOCK_EN for packet-level (wormhole) locking; undefined gives flit-level arbitration.
module output_arbiter_5 #(
  parameter int PTR_INIT = 0
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [4:0] req,
  input  logic [4:0] tail,
  input  logic       out_ready,
  output logic [4:0] grant,
  output logic [2:0] grant_idx,
  output logic       grant_valid,
  output logic       xfer,
  output logic       locked
);

  // An out-of-range start pointer falls back to port 0 so ptr never leaves 0..4.
  localparam logic [2:0] PTR_RST = (PTR_INIT >= 0 && PTR_INIT <= 4) ? 3'(PTR_INIT) : 3'd0;

  function automatic logic [2:0] next_port(input logic [2:0] idx);
    next_port = (idx >= 3'd4) ? 3'd0 : idx + 3'd1;
  endfunction

  function automatic logic [4:0] onehot(input logic [2:0] idx);
    onehot = 5'b00001 << idx;
  endfunction

  // Returns {hit, index} of the first requester at or after p, wrapping modulo 5.
  function automatic logic [3:0] rr_pick(input logic [4:0] r, input logic [2:0] p);
    logic [2:0] i;
    logic       hit;
    rr_pick = 4'd0;
    i       = p;
    hit     = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (!hit && r[i]) begin
        hit     = 1'b1;
        rr_pick = {1'b1, i};
      end
      i = next_port(i);
    end
  endfunction

  logic [2:0] ptr;
  logic [2:0] ptr_nxt;
  logic [3:0] pick;
  logic [2:0] sel_idx;
  logic       sel_vld;

  assign pick        = rr_pick(req, ptr);
  assign grant       = sel_vld ? onehot(sel_idx) : 5'd0;
  assign grant_idx   = sel_vld ? sel_idx : 3'd0;
  assign grant_valid = sel_vld;
  assign xfer        = sel_vld & out_ready;

`ifdef OUTPUT_ARB_LOCK_EN

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} mode_t;

  mode_t      mode;
  mode_t      mode_nxt;
  logic [2:0] owner;
  logic [2:0] owner_nxt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mode  <= IDLE;
      ptr   <= PTR_RST;
      owner <= 3'd0;
    end else begin
      mode  <= mode_nxt;
      ptr   <= ptr_nxt;
      owner <= owner_nxt;
    end
  end

  always_comb begin
    mode_nxt  = mode;
    ptr_nxt   = ptr;
    owner_nxt = owner;
    case (mode)
      IDLE: begin
        if (xfer) begin
          if (tail[pick[2:0]]) begin
            ptr_nxt = next_port(pick[2:0]);
          end else begin
            mode_nxt  = LOCKED;
            owner_nxt = pick[2:0];
          end
        end
      end
      LOCKED: begin
        if (xfer && tail[owner]) begin
          mode_nxt = IDLE;
          ptr_nxt  = next_port(owner);
        end
      end
      default: mode_nxt = IDLE;
    endcase
  end

  // While locked, only the owner can be granted; a dropped owner request is a bubble.
  always_comb begin
    sel_idx = pick[2:0];
    sel_vld = pick[3];
    if (mode == LOCKED) begin
      sel_idx = owner;
      sel_vld = req[owner];
    end
  end

  assign locked = (mode == LOCKED);

`else

  logic unused_tail;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr <= PTR_RST;
    end else begin
      ptr <= ptr_nxt;
    end
  end

  // Every transferred flit rotates priority past the winner.
  always_comb begin
    ptr_nxt = ptr;
    if (xfer) begin
      ptr_nxt = next_port(pick[2:0]);
    end
  end

  always_comb begin
    sel_idx = pick[2:0];
    sel_vld = pick[3];
  end

  assign locked      = 1'b0;
  assign unused_tail = ^tail;

`endif

endmodule

// File: tb/tb_output_arbiter_5.sv
// Directed bench for output_arbiter_5; lock-mode steps follow OUTPUT_ARB_LOCK_EN.
module tb_output_arbiter_5;

  logic       clk = 1'b0;
  logic       rstn;
  logic [4:0] req, tail;
  logic       out_ready;
  logic [4:0] grant;
  logic [2:0] grant_idx;
  logic       grant_valid, xfer, locked;

  logic [4:0] req2, tail2;
  logic       rdy2;
  logic [4:0] w_grant;
  logic [2:0] w_idx;
  logic       w_valid, w_xfer, w_locked;
  logic [4:0] b_grant;
  logic [2:0] b_idx;
  logic       b_valid, b_xfer, b_locked;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  output_arbiter_5 #(.PTR_INIT(0)) u_dut (
    .clk(clk), .rstn(rstn), .req(req), .tail(tail), .out_ready(out_ready),
    .grant(grant), .grant_idx(grant_idx), .grant_valid(grant_valid),
    .xfer(xfer), .locked(locked)
  );

  output_arbiter_5 #(.PTR_INIT(4)) u_wrap (
    .clk(clk), .rstn(rstn), .req(req2), .tail(tail2), .out_ready(rdy2),
    .grant(w_grant), .grant_idx(w_idx), .grant_valid(w_valid),
    .xfer(w_xfer), .locked(w_locked)
  );

  output_arbiter_5 #(.PTR_INIT(6)) u_bad (
    .clk(clk), .rstn(rstn), .req(req2), .tail(tail2), .out_ready(rdy2),
    .grant(b_grant), .grant_idx(b_idx), .grant_valid(b_valid),
    .xfer(b_xfer), .locked(b_locked)
  );

  task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    #3;
    rstn = 1'b1;
    #1;
  endtask

  initial begin
    rstn = 1'b0; req = 5'd0; tail = 5'd0; out_ready = 1'b0;
    req2 = 5'd0; tail2 = 5'd0; rdy2 = 1'b0;
    #12;
    chk("rst_grant", grant, 5'b00000);
    chk("rst_idx", {2'b0, grant_idx}, 5'd0);
    chk("rst_valid", {4'b0, grant_valid}, 5'd0);
    chk("rst_xfer", {4'b0, xfer}, 5'd0);
    chk("rst_locked", {4'b0, locked}, 5'd0);
    req = 5'b00100;
    #1;
    chk("rst_comb_grant", grant, 5'b00100);
    req = 5'd0;
    step();
    rstn = 1'b1;
    #1;

    // Wrap from PTR_INIT=4, and out-of-range PTR_INIT treated as 0.
    req2 = 5'b10001; tail2 = 5'b11111; rdy2 = 1'b1;
    #1;
    chk("wrap_g0", w_grant, 5'b10000);
    chk("wrap_idx0", {2'b0, w_idx}, 5'd4);
    chk("badptr_g0", b_grant, 5'b00001);
    step();
    chk("wrap_g1", w_grant, 5'b00001);
    step();
    chk("wrap_g2", w_grant, 5'b10000);
    req2 = 5'd0; rdy2 = 1'b0;

    // Round-robin rotation with single-flit packets.
    do_reset();
    req = 5'b10110; tail = 5'b11111; out_ready = 1'b1;
    #1;
    chk("rr_g0", grant, 5'b00010);
    chk("rr_idx0", {2'b0, grant_idx}, 5'd1);
    chk("rr_xfer0", {4'b0, xfer}, 5'd1);
    step();
    chk("rr_g1", grant, 5'b00100);
    step();
    chk("rr_g2", grant, 5'b10000);
    chk("rr_idx2", {2'b0, grant_idx}, 5'd4);
    step();
    chk("rr_g3", grant, 5'b00010);
    chk("rr_locked", {4'b0, locked}, 5'd0);

    // Backpressure: grant held, no transfer, no rotation.
    do_reset();
    req = 5'b01001; tail = 5'b11111; out_ready = 1'b0;
    #1;
    for (int c = 0; c < 3; c++) begin
      chk("stall_grant", grant, 5'b00001);
      chk("stall_xfer", {4'b0, xfer}, 5'd0);
      chk("stall_valid", {4'b0, grant_valid}, 5'd1);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("stall_rel_xfer", {4'b0, xfer}, 5'd1);
    chk("stall_rel_grant", grant, 5'b00001);
    step();
    chk("stall_next_grant", grant, 5'b01000);
    chk("stall_next_idx", {2'b0, grant_idx}, 5'd3);

    req = 5'd0;
    #1;
    chk("zero_req_grant", grant, 5'b00000);
    chk("zero_req_valid", {4'b0, grant_valid}, 5'd0);

`ifndef OUTPUT_ARB_LOCK_EN
    // Flit-level: non-tail flits still rotate and never lock.
    do_reset();
    req = 5'b01001; tail = 5'b00000; out_ready = 1'b1;
    #1;
    chk("flit_g0", grant, 5'b00001);
    step();
    chk("flit_g1", grant, 5'b01000);
    chk("flit_locked", {4'b0, locked}, 5'd0);
    step();
    chk("flit_g2", grant, 5'b00001);
`else
    // Four-flit packet from input 3 while input 0 keeps requesting.
    do_reset();
    req = 5'b00100; tail = 5'b00100; out_ready = 1'b1;
    step();
    req = 5'b01001; tail = 5'b00000;
    #1;
    chk("pkt_c1_grant", grant, 5'b01000);
    chk("pkt_c1_locked", {4'b0, locked}, 5'd0);
    step();
    chk("pkt_c2_grant", grant, 5'b01000);
    chk("pkt_c2_locked", {4'b0, locked}, 5'd1);
    step();
    chk("pkt_c3_grant", grant, 5'b01000);
    chk("pkt_c3_locked", {4'b0, locked}, 5'd1);
    step();
    tail = 5'b01000;
    #1;
    chk("pkt_c4_grant", grant, 5'b01000);
    chk("pkt_c4_locked", {4'b0, locked}, 5'd1);
    step();
    chk("pkt_after_grant", grant, 5'b00001);
    chk("pkt_after_locked", {4'b0, locked}, 5'd0);

    // Owner bubble: input 4 must not steal the locked output.
    do_reset();
    req = 5'b10010; tail = 5'b00000; out_ready = 1'b1;
    #1;
    chk("bub_head_grant", grant, 5'b00010);
    step();
    req = 5'b10000;
    #1;
    for (int c = 0; c < 2; c++) begin
      chk("bub_grant", grant, 5'b00000);
      chk("bub_locked", {4'b0, locked}, 5'd1);
      chk("bub_xfer", {4'b0, xfer}, 5'd0);
      step();
    end
    req = 5'b10010; tail = 5'b00010;
    #1;
    chk("bub_tail_grant", grant, 5'b00010);
    step();
    chk("bub_next_grant", grant, 5'b10000);
    chk("bub_next_locked", {4'b0, locked}, 5'd0);

    // Asynchronous reset while locked on input 2.
    do_reset();
    req = 5'b00100; tail = 5'b00000; out_ready = 1'b1;
    step();
    chk("arst_pre_locked", {4'b0, locked}, 5'd1);
    rstn = 1'b0;
    #1;
    chk("arst_locked", {4'b0, locked}, 5'd0);
    #1;
    rstn = 1'b1;
    req = 5'b00101; tail = 5'b11111;
    #1;
    chk("arst_after_grant", grant, 5'b00001);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/output_arbiter_5.md
# output_arbiter_5

Round-robin output-port arbiter for the 5-port router crossbar, one instance per output port. It consumes one transposed request vector: bit i set means input port i requests this output. It issues a one-hot grant that drives the crossbar select and the input-buffer pop. It holds the grant for the whole wormhole packet and rotates priority after each packet completes.

## Interface
- PTR_INIT, 0, input port index (0..4) with highest priority after reset.
- clk  input  1  clock; all state updates on the rising edge.
- rstn  input  1  asynchronous active-low reset.
- req  input  5  per-input request to this output; bit i = input port i.
- tail  input  5  bit i set when the flit at the head of input i is a tail (or single-flit packet); sampled only where req[i]=1.
- out_ready  input  1  downstream can accept a flit this cycle (credit available).
- grant  output  5  one-hot grant, or all-zero; combinational from req, state and pointer.
- grant_idx  output  3  binary index of the granted input, 0..4; 0 when grant is zero.
- grant_valid  output  1  OR of grant.
- xfer  output  1  grant_valid & out_ready; a flit moves this cycle.
- locked  output  1  registered; 1 while a multi-flit packet owns the output.

## Operation
- State: mode ∈ {IDLE, LOCKED}, ptr[2:0] ∈ 0..4, owner[2:0] ∈ 0..4.
- IDLE:
  - Grant the first set req bit, searching ptr, ptr+1, … mod 5.
  - grant is zero if req is zero.
  - On xfer with tail[grant_idx]=1: stay IDLE; ptr ← (grant_idx+1) mod 5.
  - On xfer with tail[grant_idx]=0: go LOCKED; owner ← grant_idx; ptr is unchanged.
- LOCKED:
  - grant = onehot(owner) & {5{req[owner]}}.
  - Other requests are ignored, including those from higher-priority inputs.
  - If req[owner] drops (bubble), grant is zero and the lock remains.
  - On xfer with tail[owner]=1: go IDLE; ptr ← (owner+1) mod 5.
  - On xfer with tail[owner]=0: stay LOCKED.
- Without xfer (out_ready=0), grant may still be asserted. No state changes.
- Pointer wrap: 4+1 → 0. Values 5–7 never occur. If PTR_INIT is outside 0..4, it is treated as 0.
- Invariant: grant is always one-hot or zero. grant_idx is consistent with grant.

## Timing
- Reset (rstn=0, asynchronous):
  - mode=IDLE, ptr=PTR_INIT, owner=0, locked=0.
  - grant, grant_idx, grant_valid and xfer follow req combinationally from the reset state.
- Request to grant: 0 cycles (combinational). Grant to state update: the same rising edge as xfer.
- locked rises the cycle after a head-non-tail xfer. It falls the cycle after a tail xfer.
- A new packet from any input can be granted in the cycle right after a tail xfer. There is no idle bubble.
- Reset mid-packet drops the lock immediately. Upstream must flush partial packets together with the arbiter reset.
- If tail and a new head on the same input arrive back-to-back, they are arbitrated normally. The same input wins again only if no other input lies ahead of it in priority.

## Configuration
- OUTPUT_ARB_LOCK_EN defined:
  - The LOCKED state and owner register exist. Behaviour is as above (packet-level wormhole allocation).
- OUTPUT_ARB_LOCK_EN undefined:
  - Flit-level arbitration. tail is ignored and the block stays in IDLE.
  - Every xfer sets ptr ← (grant_idx+1) mod 5.
  - locked is tied to 0. owner logic is removed.

## Test plan
- Reset then req=5'b10110, tail=5'b11111, out_ready=1 → grant sequence 00010, 00100, 10000, 00010 on successive cycles (ptr 0→2→3→0 pattern).
- LOCK_EN: input 3 sends a 4-flit packet while req[0] is continuously set → grant=01000 for 4 xfers, locked=1 cycles 2–4. Grant switches to 00001 in the cycle after the tail.
- LOCK_EN: owner 1 deasserts req for 2 cycles mid-packet while req[4]=1 → grant=0 and locked=1 during the bubble. Input 4 is never granted until input 1's tail xfer.
- out_ready=0 for 3 cycles with req=5'b01001 → grant=00001 held, xfer=0, ptr unchanged. out_ready=1 → xfer, then grant=01000.
- Wrap: PTR_INIT=4, req=5'b10001 with single-flit packets → grants 10000, 00001, 10000.
- Assert rstn=0 during LOCKED (owner=2) → locked=0 asynchronously. After release, req=5'b00101 grants per PTR_INIT.
